gnn_accel_top: RTL and testbench

Top-level sequencer of the GNN accelerator test chip. Sixteen 1-bit serial lanes are deserialised into per-lane line buffers during a load window framed by sos/eos. The block then runs four fixed-length replay iterations and raises task_complete. replay_Iter is the iteration index that the memory-dump logic samples at each iteration boundary.

---
 rtl/gnn_top_pkg.sv | 38 +++
 rtl/gnn_accel_top_spi_lane_deser.sv | 32 +++
 rtl/gnn_accel_top.sv | 197 +++++++++++++++++++
 tb/tb_gnn_accel_top.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gnn_top_pkg.sv
// Shared types and constants for the GNN accelerator top-level sequencer.
package gnn_top_pkg;

    localparam int unsigned NUM_LANES          = 16;
    localparam int unsigned MAX_BW_DEF         = 16;
    localparam int unsigned MAX_CACHE_LINE_DEF = 35;
    localparam int unsigned ITER_CYCLES_DEF    = 64;
    localparam int unsigned NUM_ITERS          = 4;
    localparam int unsigned RD_LANE_W          = 4;
    localparam int unsigned RD_ADDR_W          = 6;
    localparam int unsigned ITER_W             = 2;

    // Lane indices in port order
    localparam int unsigned LANE_PACKET    = 0;
    localparam int unsigned LANE_NBR_INFO0 = 1;
    localparam int unsigned LANE_NBR_INFO1 = 2;
    localparam int unsigned LANE_NBR_ID0   = 3;
    localparam int unsigned LANE_NBR_ID1   = 4;
    localparam int unsigned LANE_NBR_ID2   = 5;
    localparam int unsigned LANE_NBR_ID3   = 6;
    localparam int unsigned LANE_FV_INFO0  = 7;
    localparam int unsigned LANE_FV0       = 8;
    localparam int unsigned LANE_FV1       = 9;
    localparam int unsigned LANE_FV2       = 10;
    localparam int unsigned LANE_FV3       = 11;
    localparam int unsigned LANE_BIG_FV0   = 12;
    localparam int unsigned LANE_BIG_FV1   = 13;
    localparam int unsigned LANE_BIG_FV2   = 14;
    localparam int unsigned LANE_BIG_FV3   = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPLAY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gnn_accel_top_spi_lane_deser.sv
// One serial lane: MSB-first shift register with a word-complete strobe.
// The full word is presented combinationally in the cycle its last bit arrives.
module spi_lane_deser #(
    parameter int unsigned MAX_BW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_shift_en,
    input  logic              i_last,
    input  logic              i_bit,
    output logic [MAX_BW-1:0] o_word_c,
    output logic              o_wr_c
);

    // Only MAX_BW-1 history bits are needed; the newest bit comes straight from i_bit
    logic [MAX_BW-2:0] r_shift;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[MAX_BW-3:0], i_bit};
        end
    end

    assign o_word_c = {r_shift, i_bit};
    assign o_wr_c   = i_shift_en & i_last;

endmodule

// File: rtl/gnn_accel_top.sv
// GNN accelerator sequencer: 16-lane serial load, four fixed-length replay iterations, done flag.
// Optional macro LOAD_OVERFLOW_EN adds a sticky load_overflow output.
module gnn_accel_top
    import gnn_top_pkg::*;
#(
    parameter int unsigned MAX_BW         = MAX_BW_DEF,
    parameter int unsigned MAX_CACHE_LINE = MAX_CACHE_LINE_DEF,
    parameter int unsigned ITER_CYCLES    = ITER_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sos,
    input  logic                 eos,
    input  logic                 Packet_Bank_data,
    input  logic                 Neighbor_Info_Bank0_data,
    input  logic                 Neighbor_Info_Bank1_data,
    input  logic                 Neighbor_ID_Bank0_data,
    input  logic                 Neighbor_ID_Bank1_data,
    input  logic                 Neighbor_ID_Bank2_data,
    input  logic                 Neighbor_ID_Bank3_data,
    input  logic                 FV_Info_Bank0_data,
    input  logic                 FV_Bank0_data,
    input  logic                 FV_Bank1_data,
    input  logic                 FV_Bank2_data,
    input  logic                 FV_Bank3_data,
    input  logic                 Big_FV_Bank0_data,
    input  logic                 Big_FV_Bank1_data,
    input  logic                 Big_FV_Bank2_data,
    input  logic                 Big_FV_Bank3_data,
    input  logic [RD_LANE_W-1:0] rd_lane,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic [MAX_BW-1:0]    rd_data,
    output logic [ITER_W-1:0]    replay_Iter,
    output logic                 task_complete
`ifdef LOAD_OVERFLOW_EN
    ,
    output logic                 load_overflow
`endif
);

    localparam int unsigned BIT_W = $clog2(MAX_BW);
    localparam int unsigned IDX_W = $clog2(MAX_CACHE_LINE + 1);
    localparam int unsigned CYC_W = $clog2(ITER_CYCLES);

    state_t                r_state;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [IDX_W-1:0]      r_word_idx;
    logic [CYC_W-1:0]      r_cyc_cnt;
    logic [ITER_W-1:0]     r_iter;
    logic                  r_done;
    logic [MAX_BW-1:0]     r_rd_data;
    logic [MAX_BW-1:0]     r_buf [NUM_LANES][MAX_CACHE_LINE];

    logic [NUM_LANES-1:0]  w_lane_bit;
    logic [MAX_BW-1:0]     w_word [NUM_LANES];
    logic [NUM_LANES-1:0]  w_wr;
    logic                  w_room;
    logic                  w_shift_en;
    logic                  w_last;
    logic                  w_clr;
    logic                  w_cyc_tc;
    logic                  w_rd_in_range;

    assign w_lane_bit[LANE_PACKET]    = Packet_Bank_data;
    assign w_lane_bit[LANE_NBR_INFO0] = Neighbor_Info_Bank0_data;
    assign w_lane_bit[LANE_NBR_INFO1] = Neighbor_Info_Bank1_data;
    assign w_lane_bit[LANE_NBR_ID0]   = Neighbor_ID_Bank0_data;
    assign w_lane_bit[LANE_NBR_ID1]   = Neighbor_ID_Bank1_data;
    assign w_lane_bit[LANE_NBR_ID2]   = Neighbor_ID_Bank2_data;
    assign w_lane_bit[LANE_NBR_ID3]   = Neighbor_ID_Bank3_data;
    assign w_lane_bit[LANE_FV_INFO0]  = FV_Info_Bank0_data;
    assign w_lane_bit[LANE_FV0]       = FV_Bank0_data;
    assign w_lane_bit[LANE_FV1]       = FV_Bank1_data;
    assign w_lane_bit[LANE_FV2]       = FV_Bank2_data;
    assign w_lane_bit[LANE_FV3]       = FV_Bank3_data;
    assign w_lane_bit[LANE_BIG_FV0]   = Big_FV_Bank0_data;
    assign w_lane_bit[LANE_BIG_FV1]   = Big_FV_Bank1_data;
    assign w_lane_bit[LANE_BIG_FV2]   = Big_FV_Bank2_data;
    assign w_lane_bit[LANE_BIG_FV3]   = Big_FV_Bank3_data;

    // eos wins over a bit in the same cycle; a full buffer swallows further bits
    assign w_room        = (r_word_idx < IDX_W'(MAX_CACHE_LINE));
    assign w_shift_en    = (r_state == ST_LOAD) && !eos && w_room;
    assign w_last        = (r_bit_cnt == BIT_W'(MAX_BW - 1));
    assign w_clr         = (r_state == ST_IDLE) && sos;
    assign w_cyc_tc      = (r_cyc_cnt == CYC_W'(ITER_CYCLES - 1));
    assign w_rd_in_range = (rd_addr < RD_ADDR_W'(MAX_CACHE_LINE));

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        spi_lane_deser #(
            .MAX_BW (MAX_BW)
        ) u_deser (
            .clk        (clk),
            .reset      (reset),
            .i_clr      (w_clr),
            .i_shift_en (w_shift_en),
            .i_last     (w_last),
            .i_bit      (w_lane_bit[g]),
            .o_word_c   (w_word[g]),
            .o_wr_c     (w_wr[g])
        );
    end

    // Sequencer: load framing, replay iteration timing, done flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_word_idx <= '0;
            r_cyc_cnt  <= '0;
            r_iter     <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sos) begin
                        r_state    <= ST_LOAD;
                        r_bit_cnt  <= '0;
                        r_word_idx <= '0;
                    end
                end
                ST_LOAD: begin
                    if (eos) begin
                        r_state   <= ST_REPLAY;
                        r_bit_cnt <= '0;
                        r_cyc_cnt <= '0;
                    end else if (w_room) begin
                        if (w_last) begin
                            r_bit_cnt  <= '0;
                            r_word_idx <= r_word_idx + IDX_W'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_REPLAY: begin
                    if (w_cyc_tc) begin
                        r_cyc_cnt <= '0;
                        if (r_iter == ITER_W'(NUM_ITERS - 1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_iter <= r_iter + ITER_W'(1);
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line buffers survive reset so a dump can still read them afterwards
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_wr[l]) begin
                r_buf[l][r_word_idx] <= w_word[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_buf[rd_lane][rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

`ifdef LOAD_OVERFLOW_EN
    logic r_overflow;

    // Any bit presented while the buffers are already full
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if ((r_state == ST_LOAD) && !eos && !w_room) begin
            r_overflow <= 1'b1;
        end
    end

    assign load_overflow = r_overflow;
`endif

    assign rd_data       = r_rd_data;
    assign replay_Iter   = r_iter;
    assign task_complete = r_done;

endmodule

// File: tb/tb_gnn_accel_top.sv
// Self-checking bench for gnn_accel_top: serial loads, debug reads via a scoreboard queue, replay timing.
module tb_gnn_accel_top;
    import gnn_top_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sos;
    logic        eos;
    logic [15:0] lanes;
    logic [3:0]  rd_lane;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  replay_Iter;
    logic        task_complete;
`ifdef LOAD_OVERFLOW_EN
    logic        load_overflow;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_buf [16][35];
    logic [15:0] rd_q [$];

    always #5 clk = ~clk;

    gnn_accel_top dut (
        .clk                      (clk),
        .reset                    (reset),
        .sos                      (sos),
        .eos                      (eos),
        .Packet_Bank_data         (lanes[0]),
        .Neighbor_Info_Bank0_data (lanes[1]),
        .Neighbor_Info_Bank1_data (lanes[2]),
        .Neighbor_ID_Bank0_data   (lanes[3]),
        .Neighbor_ID_Bank1_data   (lanes[4]),
        .Neighbor_ID_Bank2_data   (lanes[5]),
        .Neighbor_ID_Bank3_data   (lanes[6]),
        .FV_Info_Bank0_data       (lanes[7]),
        .FV_Bank0_data            (lanes[8]),
        .FV_Bank1_data            (lanes[9]),
        .FV_Bank2_data            (lanes[10]),
        .FV_Bank3_data            (lanes[11]),
        .Big_FV_Bank0_data        (lanes[12]),
        .Big_FV_Bank1_data        (lanes[13]),
        .Big_FV_Bank2_data        (lanes[14]),
        .Big_FV_Bank3_data        (lanes[15]),
        .rd_lane                  (rd_lane),
        .rd_addr                  (rd_addr),
        .rd_data                  (rd_data),
        .replay_Iter              (replay_Iter),
        .task_complete            (task_complete)
`ifdef LOAD_OVERFLOW_EN
        ,
        .load_overflow            (load_overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int n, input int k, input logic [15:0] seed);
        return 16'((n << 8) | k) ^ seed;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sos, nbits of lane data (word k of lane n = pat), then eos; returns just after the REPLAY-entry edge
    task automatic load_stream(input int nbits, input logic [15:0] seed, input int sos_glitch);
        logic [15:0] w;
        logic [3:0]  bi;
        sos   = 1'b1;
        lanes = 16'($urandom);
        step();
        for (int b = 0; b < nbits; b++) begin
            bi = 4'(15 - (b % 16));
            for (int n = 0; n < 16; n++) begin
                w        = pat(n, b / 16, seed);
                lanes[n] = w[bi];
            end
            sos = (b == sos_glitch);
            step();
        end
        sos   = 1'b0;
        eos   = 1'b1;
        lanes = 16'($urandom);
        step();
        eos = 1'b0;
        for (int k = 0; k < 35; k++) begin
            if ((k + 1) * 16 <= nbits) begin
                for (int n = 0; n < 16; n++) exp_buf[n][k] = pat(n, k, seed);
            end
        end
    endtask

    // Called right after REPLAY entry (k = 0); checks iteration and done flag at chosen offsets
    task automatic replay_check(input int stop_at);
        int exp_iter;
        for (int k = 0; k <= stop_at; k++) begin
            if (k inside {0, 63, 64, 127, 128, 191, 192, 255, 256, 300}) begin
                exp_iter = (k >= 192) ? 3 : k / 64;
                check($sformatf("iter@%0d", k), 32'(replay_Iter), 32'(exp_iter));
                check($sformatf("done@%0d", k), 32'(task_complete), 32'(k >= 256));
            end
            if (k < stop_at) step();
        end
    endtask

    task automatic read_chk(input int lane, input int addr, input logic [15:0] exp);
        rd_lane = 4'(lane);
        rd_addr = 6'(addr);
        rd_q.push_back(exp);
        step();
        check($sformatf("rd[%0d][%0d]", lane, addr), 32'(rd_data), 32'(rd_q.pop_front()));
    endtask

    initial begin
        reset   = 1'b0;
        sos     = 1'b0;
        eos     = 1'b0;
        lanes   = '0;
        rd_lane = '0;
        rd_addr = '0;
        repeat (3) step();
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_iter", 32'(replay_Iter), 32'd0);
        check("rst_done", 32'(task_complete), 32'd0);

        reset   = 1'b1;
        rd_addr = 6'd63;
        repeat (10) step();
        check("idle_iter", 32'(replay_Iter), 32'd0);
        check("idle_done", 32'(task_complete), 32'd0);
        check("idle_rd_data", 32'(rd_data), 32'd0);

        // Full load: 35 words per lane
        load_stream(560, 16'h0000, -1);
`ifdef LOAD_OVERFLOW_EN
        check("ovf_exact", 32'(load_overflow), 32'd0);
`endif
        replay_check(300);
        read_chk(5, 3, 16'h0503);
        read_chk(0, 0, exp_buf[0][0]);
        read_chk(15, 34, exp_buf[15][34]);
        read_chk(10, 17, exp_buf[10][17]);
        read_chk(5, 40, 16'h0000);
        read_chk(3, 35, 16'h0000);
        read_chk(15, 63, 16'h0000);
        check("done_sticky", 32'(task_complete), 32'd1);
        check("iter_hold", 32'(replay_Iter), 32'd3);

        // Partial load of 20 bits with a stray sos inside LOAD, then reset during iteration 2
        reset = 1'b0;
        step();
        reset = 1'b1;
        load_stream(20, 16'hA5A5, 10);
        replay_check(130);
        reset = 1'b0;
        step();
        check("midrst_iter", 32'(replay_Iter), 32'd0);
        check("midrst_done", 32'(task_complete), 32'd0);
        reset = 1'b1;
        read_chk(0, 0, exp_buf[0][0]);
        read_chk(0, 1, exp_buf[0][1]);
        read_chk(9, 0, exp_buf[9][0]);
        read_chk(9, 1, 16'h0901);
        read_chk(12, 2, exp_buf[12][2]);

        // Overlong load: extra bits dropped, no wrap onto word 0
        load_stream(570, 16'h3C00, -1);
`ifdef LOAD_OVERFLOW_EN
        check("ovf_excess", 32'(load_overflow), 32'd1);
`endif
        replay_check(300);
        read_chk(0, 0, exp_buf[0][0]);
        read_chk(7, 34, exp_buf[7][34]);
        read_chk(15, 34, exp_buf[15][34]);
        read_chk(4, 1, exp_buf[4][1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
